// File: rtl/cam_axis_capture.sv
// OV7670-style 8-bit RGB565 camera bus to AXI4-Stream video (24-bit RGB) with a small output FIFO.
// State | meaning:  IDLE = not capturing | VBLANK = armed, waiting for vsync fall | ACTIVE = frame lines in progress
module cam_axis_capture #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        Cclk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic [23:0] m_axis_video_tdata,
  output logic        m_axis_video_tvalid,
  output logic        m_axis_video_tuser,
  output logic        m_axis_video_tlast,
  input  logic        m_axis_video_tready,
  output logic [15:0] frame_cnt,
  output logic        ovf_err,
  output logic        line_err,
  input  logic        clr_err
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [XW-1:0] X_MAX    = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_MAX    = YW'(V_ACTIVE);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_VBLANK, S_ACTIVE} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_vs1, r_vs2, r_hr1, r_hr2;
  logic [7:0]     r_d1;
  logic [7:0]     r_hi;
  logic           r_phase;
  logic           r_sof_pend;
  logic [XW-1:0]  r_x;
  logic [YW-1:0]  r_y;
  logic           r_px_vld, r_px_user, r_px_last;
  logic [23:0]    r_px_data;
  logic [25:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wp, r_rp;
  logic [AW:0]    r_cnt;
  logic [15:0]    r_frame_cnt;
  logic           r_ovf_err, r_line_err;

  logic           w_vs_rise, w_vs_fall, w_hr_fall, w_active, w_frame_end;
  logic           w_px_form, w_px_new, w_px_accept, w_px_drop, w_long;
  logic           w_full, w_valid, w_push, w_pop, w_stage_free;
  logic           w_line_err_set;
  logic [4:0]     w_r5, w_b5;
  logic [5:0]     w_g6;
  logic [23:0]    w_rgb;
  logic [25:0]    w_head;

  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      r_vs1 <= 1'b0;
      r_vs2 <= 1'b0;
      r_hr1 <= 1'b0;
      r_hr2 <= 1'b0;
      r_d1  <= '0;
    end else begin
      r_vs1 <= cam_vsync;
      r_vs2 <= r_vs1;
      r_hr1 <= cam_href;
      r_hr2 <= r_hr1;
      r_d1  <= cam_data;
    end
  end

  assign w_vs_rise   = r_vs1 & ~r_vs2;
  assign w_vs_fall   = ~r_vs1 & r_vs2;
  assign w_hr_fall   = ~r_hr1 & r_hr2;
  assign w_active    = (r_state == S_ACTIVE);
  assign w_frame_end = w_active & w_vs_rise;

  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (enable && w_vs_rise) w_state_nxt = S_VBLANK;
      S_VBLANK: if (w_vs_fall) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_vs_rise) w_state_nxt = enable ? S_VBLANK : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  assign w_r5  = r_hi[7:3];
  assign w_g6  = {r_hi[2:0], r_d1[7:5]};
  assign w_b5  = r_d1[4:0];
  assign w_rgb = {w_r5, w_r5[4:2], w_g6, w_g6[5:4], w_b5, w_b5[4:2]};

  assign w_full       = (r_cnt == FULL_CNT);
  assign w_valid      = (r_cnt != '0);
  assign w_pop        = w_valid & m_axis_video_tready;
  assign w_push       = r_px_vld & (~w_full | w_pop);
  assign w_stage_free = ~r_px_vld | w_push;

  assign w_px_form   = w_active & r_hr1 & r_phase;
  assign w_px_new    = w_px_form & (r_x < X_MAX) & (r_y < Y_MAX);
  assign w_px_accept = w_px_new & w_stage_free;
  assign w_px_drop   = w_px_new & ~w_stage_free;
  assign w_long      = w_px_form & (r_x >= X_MAX) & (r_y < Y_MAX);

  assign w_line_err_set = w_long
                        | (w_active & w_hr_fall & r_phase & (r_y < Y_MAX))
                        | (w_active & w_hr_fall & (r_x != '0) & (r_x < X_MAX))
                        | (w_frame_end & (r_y < Y_MAX));

  // x advances for every in-window pixel, even a dropped one, so tlast stays on the true line end
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      r_x        <= '0;
      r_y        <= '0;
      r_phase    <= 1'b0;
      r_hi       <= '0;
      r_sof_pend <= 1'b0;
    end else if ((r_state == S_VBLANK) && w_vs_fall) begin
      r_x        <= '0;
      r_y        <= '0;
      r_phase    <= 1'b0;
      r_sof_pend <= 1'b1;
    end else if (w_active) begin
      if (r_hr1) begin
        r_phase <= ~r_phase;
        if (!r_phase)    r_hi       <= r_d1;
        if (w_px_new)    r_x        <= r_x + XW'(1);
        if (w_px_accept) r_sof_pend <= 1'b0;
      end else if (w_hr_fall) begin
        if (r_x != '0) r_y <= r_y + YW'(1);
        r_x     <= '0;
        r_phase <= 1'b0;
      end
    end
  end

  // Stage register holds one pixel while the FIFO is full; the next pixel is dropped only if it is still occupied
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      r_px_vld  <= 1'b0;
      r_px_user <= 1'b0;
      r_px_last <= 1'b0;
      r_px_data <= '0;
    end else if (w_px_accept) begin
      r_px_vld  <= 1'b1;
      r_px_user <= r_sof_pend;
      r_px_last <= (r_x == X_LAST);
      r_px_data <= w_rgb;
    end else if (w_push) begin
      r_px_vld  <= 1'b0;
    end
  end

  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= {r_px_user, r_px_last, r_px_data};
        r_wp        <= r_wp + AW'(1);
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW + 1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW + 1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      r_frame_cnt <= '0;
      r_ovf_err   <= 1'b0;
      r_line_err  <= 1'b0;
    end else begin
      if (w_frame_end && (r_y == Y_MAX)) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_px_drop)    r_ovf_err <= 1'b1;
      else if (clr_err) r_ovf_err <= 1'b0;
      if (w_line_err_set) r_line_err <= 1'b1;
      else if (clr_err)   r_line_err <= 1'b0;
    end
  end

  assign w_head              = r_mem[r_rp];
  assign m_axis_video_tvalid = w_valid;
  assign m_axis_video_tdata  = w_valid ? w_head[23:0] : 24'd0;
  assign m_axis_video_tlast  = w_valid & w_head[24];
  assign m_axis_video_tuser  = w_valid & w_head[25];
  assign frame_cnt           = r_frame_cnt;
  assign ovf_err             = r_ovf_err;
  assign line_err            = r_line_err;

endmodule

// File: tb/tb_cam_axis_capture.sv
// Directed bench for cam_axis_capture on a 4x2 frame; expected values are hand-computed per step.
module tb_cam_axis_capture;

  logic        Cclk = 1'b0;
  logic        rstn;
  logic        enable;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic [23:0] m_axis_video_tdata;
  logic        m_axis_video_tvalid;
  logic        m_axis_video_tuser;
  logic        m_axis_video_tlast;
  logic        m_axis_video_tready;
  logic [15:0] frame_cnt;
  logic        ovf_err;
  logic        line_err;
  logic        clr_err;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_valid_cyc = 0;
  logic [25:0] beats [$];

  cam_axis_capture #(.H_ACTIVE(4), .V_ACTIVE(2), .FIFO_DEPTH(4)) dut (
    .Cclk               (Cclk),
    .rstn               (rstn),
    .enable             (enable),
    .cam_vsync          (cam_vsync),
    .cam_href           (cam_href),
    .cam_data           (cam_data),
    .m_axis_video_tdata (m_axis_video_tdata),
    .m_axis_video_tvalid(m_axis_video_tvalid),
    .m_axis_video_tuser (m_axis_video_tuser),
    .m_axis_video_tlast (m_axis_video_tlast),
    .m_axis_video_tready(m_axis_video_tready),
    .frame_cnt          (frame_cnt),
    .ovf_err            (ovf_err),
    .line_err           (line_err),
    .clr_err            (clr_err)
  );

  always #5 Cclk = ~Cclk;

  // Inputs only change 1 unit after a rising edge, so the falling edge sees the values the next edge will use
  always @(negedge Cclk) begin
    if (m_axis_video_tvalid) n_valid_cyc++;
    if (m_axis_video_tvalid && m_axis_video_tready)
      beats.push_back({m_axis_video_tuser, m_axis_video_tlast, m_axis_video_tdata});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Cclk);
      #1;
    end
  endtask

  task automatic send_px(input logic [7:0] hi, input logic [7:0] lo);
    cam_href = 1'b1;
    cam_data = hi;
    tick(1);
    cam_data = lo;
    tick(1);
  endtask

  task automatic line_end();
    cam_href = 1'b0;
    cam_data = 8'h00;
    tick(2);
  endtask

  task automatic red_line(input int n);
    for (int i = 0; i < n; i++) send_px(8'hF8, 8'h00);
    line_end();
  endtask

  task automatic vs_high();
    cam_vsync = 1'b1;
    tick(4);
  endtask

  task automatic vs_low();
    cam_vsync = 1'b0;
    tick(4);
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    tick(1);
  endtask

  initial begin
    int          base;
    int          vc;
    logic [23:0] bexp [5];
    bexp[0] = 24'h000008;
    bexp[1] = 24'h000010;
    bexp[2] = 24'h000018;
    bexp[3] = 24'h000021;
    bexp[4] = 24'h000029;

    rstn = 1'b0; enable = 1'b1; cam_vsync = 1'b0; cam_href = 1'b0;
    cam_data = 8'h00; m_axis_video_tready = 1'b1; clr_err = 1'b0;
    tick(3);
    check("rst_tvalid", 32'(m_axis_video_tvalid), 0);
    check("rst_tdata",  32'(m_axis_video_tdata), 0);
    check("rst_tuser",  32'(m_axis_video_tuser), 0);
    check("rst_tlast",  32'(m_axis_video_tlast), 0);
    check("rst_frame",  32'(frame_cnt), 0);
    check("rst_ovf",    32'(ovf_err), 0);
    check("rst_lerr",   32'(line_err), 0);
    rstn = 1'b1;
    tick(2);

    // Frame 1: 4x2 solid red
    vs_high();
    vs_low();
    base = beats.size();
    red_line(4);
    red_line(4);
    vs_high();
    check("f1_nbeats", 32'(beats.size() - base), 8);
    for (int i = 0; i < 8; i++) begin
      if (base + i < beats.size()) begin
        check($sformatf("f1_data%0d", i), 32'(beats[base+i][23:0]), 'hFF0000);
        check($sformatf("f1_user%0d", i), 32'(beats[base+i][25]), (i == 0) ? 1 : 0);
        check($sformatf("f1_last%0d", i), 32'(beats[base+i][24]), (i == 3 || i == 7) ? 1 : 0);
      end
    end
    check("f1_frame", 32'(frame_cnt), 1);
    check("f1_lerr",  32'(line_err), 0);

    // Frame 2: latency of the first pixel (0x00,0x1F -> pure blue)
    vs_low();
    base = beats.size();
    send_px(8'h00, 8'h1F);
    cam_data = 8'h00;
    tick(1);
    check("lat_T1_tvalid", 32'(m_axis_video_tvalid), 0);
    cam_data = 8'h1F;
    tick(1);
    check("lat_T2_tvalid", 32'(m_axis_video_tvalid), 1);
    check("lat_T2_tdata",  32'(m_axis_video_tdata), 'h0000FF);
    check("lat_T2_tuser",  32'(m_axis_video_tuser), 1);
    check("lat_T2_tlast",  32'(m_axis_video_tlast), 0);
    send_px(8'h00, 8'h1F);
    send_px(8'h00, 8'h1F);
    line_end();
    red_line(4);
    vs_high();
    check("f2_nbeats", 32'(beats.size() - base), 8);
    check("f2_ovf",    32'(ovf_err), 0);
    check("f2_lerr",   32'(line_err), 0);
    check("f2_frame",  32'(frame_cnt), 2);

    // Frame 3: backpressure fills FIFO, stage holds one more, then overflow
    vs_low();
    base = beats.size();
    m_axis_video_tready = 1'b0;
    for (int k = 1; k <= 4; k++) send_px(8'h00, 8'(k));
    line_end();
    check("bp_tvalid", 32'(m_axis_video_tvalid), 1);
    check("bp_tdata0", 32'(m_axis_video_tdata), 'h000008);
    check("bp_tuser0", 32'(m_axis_video_tuser), 1);
    check("bp_ovf0",   32'(ovf_err), 0);
    tick(3);
    check("bp_tdata_hold", 32'(m_axis_video_tdata), 'h000008);
    send_px(8'h00, 8'h05);
    check("bp_ovf_5th", 32'(ovf_err), 0);
    for (int k = 6; k <= 8; k++) send_px(8'h00, 8'(k));
    line_end();
    check("bp_ovf_6th", 32'(ovf_err), 1);
    check("bp_lerr",    32'(line_err), 0);
    check("bp_nbeats_held", 32'(beats.size() - base), 0);
    m_axis_video_tready = 1'b1;
    tick(10);
    check("bp_nbeats", 32'(beats.size() - base), 5);
    for (int i = 0; i < 5; i++) begin
      if (base + i < beats.size()) begin
        check($sformatf("bp_data%0d", i), 32'(beats[base+i][23:0]), 32'(bexp[i]));
        check($sformatf("bp_user%0d", i), 32'(beats[base+i][25]), (i == 0) ? 1 : 0);
        check($sformatf("bp_last%0d", i), 32'(beats[base+i][24]), (i == 3) ? 1 : 0);
      end
    end
    vs_high();
    check("f3_frame", 32'(frame_cnt), 3);
    clr_pulse();
    check("bp_ovf_clr", 32'(ovf_err), 0);

    // Frame 4: short line, then odd byte count
    vs_low();
    base = beats.size();
    red_line(3);
    check("short_lerr", 32'(line_err), 1);
    clr_pulse();
    check("short_lerr_clr", 32'(line_err), 0);
    send_px(8'hF8, 8'h00);
    send_px(8'hF8, 8'h00);
    send_px(8'hF8, 8'h00);
    cam_href = 1'b1;
    cam_data = 8'hF8;
    tick(1);
    line_end();
    check("odd_lerr", 32'(line_err), 1);
    tick(2);
    check("odd_nbeats", 32'(beats.size() - base), 6);
    for (int i = 0; i < 6; i++) begin
      if (base + i < beats.size())
        check($sformatf("odd_last%0d", i), 32'(beats[base+i][24]), 0);
    end
    clr_pulse();
    check("odd_lerr_clr", 32'(line_err), 0);
    vs_high();
    check("f4_lerr",  32'(line_err), 0);
    check("f4_frame", 32'(frame_cnt), 4);

    // Frame 5: reset in the middle of line 0
    vs_low();
    m_axis_video_tready = 1'b0;
    send_px(8'hF8, 8'h00);
    send_px(8'hF8, 8'h00);
    cam_href = 1'b0;
    tick(3);
    check("mrst_pre_tvalid", 32'(m_axis_video_tvalid), 1);
    rstn = 1'b0;
    #1;
    check("mrst_tvalid", 32'(m_axis_video_tvalid), 0);
    check("mrst_tdata",  32'(m_axis_video_tdata), 0);
    check("mrst_frame",  32'(frame_cnt), 0);
    check("mrst_lerr",   32'(line_err), 0);
    tick(2);
    rstn = 1'b1;
    m_axis_video_tready = 1'b1;
    tick(2);
    base = beats.size();
    vs_high();
    vs_low();
    red_line(4);
    red_line(4);
    vs_high();
    check("mrst_nbeats", 32'(beats.size() - base), 8);
    if (base < beats.size())
      check("mrst_user0", 32'(beats[base][25]), 1);
    check("mrst_frame_after", 32'(frame_cnt), 1);

    // Frame 6: enable dropped mid-frame; frame completes, then capture stops
    vs_low();
    base = beats.size();
    red_line(4);
    enable = 1'b0;
    red_line(4);
    vs_high();
    check("en_nbeats", 32'(beats.size() - base), 8);
    check("en_frame",  32'(frame_cnt), 2);
    vc = n_valid_cyc;
    vs_low();
    red_line(4);
    red_line(4);
    vs_high();
    vs_low();
    tick(4);
    check("en_off_tvalid_cycles", 32'(n_valid_cyc - vc), 0);
    check("en_off_frame", 32'(frame_cnt), 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
